// File: rtl/b_dly_cal_ctrl.sv
// Successive-approximation calibration controller for the b_dly_f64c8 delay line.
// Binary-searches a 9-bit delay code against a phase detector using majority voting per trial bit.
module b_dly_cal_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int NSAMP      = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_pd,
  input  logic       i_man_en,
  input  logic [8:0] i_man_sel,
  output logic [8:0] o_dly_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sat
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SAMP_LAST   = 8'(NSAMP - 1);
  localparam logic [7:0] HALF        = 8'(NSAMP / 2);

  state_t     state_q, state_d;
  logic [8:0] result_q, result_d;
  logic [3:0] k_q, k_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] samp_cnt_q, samp_cnt_d;
  logic [7:0] ones_q, ones_d;
  logic [8:0] lk_sel_q, lk_sel_d;
  logic [8:0] dly_q, dly_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sat_q, sat_d;

  logic [8:0] idle_sel_s;
  logic [8:0] trial_s;
  logic [8:0] decided_s;
  logic       abort_s;

  assign idle_sel_s = i_man_en ? i_man_sel : lk_sel_q;
  assign trial_s    = result_q | (9'd1 << k_q);
  // Majority of "late" votes means the trial code overshoots, so bit k is dropped.
  assign decided_s  = (ones_q > HALF) ? (trial_s & ~(9'd1 << k_q)) : trial_s;
  assign abort_s    = i_abort && (state_q != S_IDLE);

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every in-flight transition
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = i_start ? S_SETTLE : S_IDLE;
        S_SETTLE: state_d = (settle_cnt_q == SETTLE_LAST) ? S_SAMPLE : S_SETTLE;
        S_SAMPLE: state_d = (samp_cnt_q == SAMP_LAST) ? S_DECIDE : S_SAMPLE;
        S_DECIDE: state_d = (k_q == 4'd0) ? S_DONE : S_SETTLE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    result_d     = result_q;
    k_d          = k_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    ones_d       = ones_q;
    lk_sel_d     = lk_sel_q;
    dly_d        = dly_q;
    sat_d        = sat_q;
    done_d       = 1'b0;
    busy_d       = (state_d != S_IDLE);
    if (abort_s) begin
      settle_cnt_d = 8'd0;
      samp_cnt_d   = 8'd0;
      ones_d       = 8'd0;
      dly_d        = idle_sel_s;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            result_d     = 9'd0;
            k_d          = 4'd8;
            settle_cnt_d = 8'd0;
            samp_cnt_d   = 8'd0;
            ones_d       = 8'd0;
            dly_d        = 9'd256;
          end else begin
            dly_d = idle_sel_s;
          end
        end
        S_SETTLE: begin
          if (state_d == S_SAMPLE) begin
            settle_cnt_d = 8'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          ones_d = ones_q + {7'd0, i_pd};
          if (state_d == S_DECIDE) begin
            samp_cnt_d = 8'd0;
          end else begin
            samp_cnt_d = samp_cnt_q + 8'd1;
          end
        end
        S_DECIDE: begin
          result_d     = decided_s;
          settle_cnt_d = 8'd0;
          samp_cnt_d   = 8'd0;
          ones_d       = 8'd0;
          if (k_q != 4'd0) begin
            k_d   = k_q - 4'd1;
            dly_d = decided_s | (9'd1 << (k_q - 4'd1));
          end else begin
            done_d   = 1'b1;
            lk_sel_d = decided_s;
            sat_d    = (decided_s == 9'd0) || (decided_s == 9'd511);
            dly_d    = decided_s;
          end
        end
        S_DONE:  dly_d = idle_sel_s;
        default: dly_d = idle_sel_s;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      result_q     <= 9'd0;
      k_q          <= 4'd8;
      settle_cnt_q <= 8'd0;
      samp_cnt_q   <= 8'd0;
      ones_q       <= 8'd0;
      lk_sel_q     <= 9'd0;
      dly_q        <= 9'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      result_q     <= result_d;
      k_q          <= k_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      ones_q       <= ones_d;
      lk_sel_q     <= lk_sel_d;
      dly_q        <= dly_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
    end
  end

  assign o_dly_sel = dly_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_b_dly_cal_ctrl.sv
// Self-checking bench for b_dly_cal_ctrl: a phase-detector plant feeds the DUT and an
// ideal binary-search model predicts each calibration result.
module tb_b_dly_cal_ctrl;

  localparam int SETTLE = 16;
  localparam int NS     = 8;
  localparam int LAT    = 9 * (SETTLE + NS + 1) + 1;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_pd;
  logic       i_man_en = 1'b0;
  logic [8:0] i_man_sel = 9'd0;
  logic [8:0] o_dly_sel;
  logic       o_busy, o_done, o_sat;

  int tests_run = 0;
  int tests_failed = 0;

  // Plant: 0 = threshold at pd_par, 1 = always early, 2 = always late, 3 = pd_par ones per 8 cycles
  int pd_mode = 1;
  int pd_par  = 0;
  int tb_cyc  = 0;

  int         r_lat, r_ndone;
  logic       r_busy1, r_busy_ab, r_busy_end, r_sat_end;
  logic [8:0] r_dly1, r_dly_ab, r_dly_end;

  b_dly_cal_ctrl #(.SETTLE_CYC(SETTLE), .NSAMP(NS)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort), .i_pd(i_pd),
    .i_man_en(i_man_en), .i_man_sel(i_man_sel),
    .o_dly_sel(o_dly_sel), .o_busy(o_busy), .o_done(o_done), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) tb_cyc <= tb_cyc + 1;

  assign i_pd = (pd_mode == 0) ? (int'(o_dly_sel) >= pd_par) :
                (pd_mode == 2) ? 1'b1 :
                (pd_mode == 3) ? ((tb_cyc % 8) < pd_par) : 1'b0;

  // Ideal binary search: each trial bit is kept unless more than half the votes say "late".
  function automatic logic [8:0] model_cal(input int mode, input int par);
    int res;
    int trial;
    int ones;
    res = 0;
    for (int k = 8; k >= 0; k--) begin
      trial = res + (1 << k);
      case (mode)
        0:       ones = (trial >= par) ? NS : 0;
        1:       ones = 0;
        2:       ones = NS;
        default: ones = par;
      endcase
      if (ones <= NS / 2) res = trial;
    end
    return 9'(res);
  endfunction

  function automatic logic sat_of(input logic [8:0] v);
    return (v == 9'd0) || (v == 9'd511);
  endfunction

  // Pulse start (caller sits between edges); cycle 1 is the one right after the start edge.
  task automatic do_cal(input int abort_at, input int start_at);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    r_lat = -1; r_ndone = 0; r_busy1 = 1'b0; r_dly1 = 9'd0; r_busy_ab = 1'b1; r_dly_ab = 9'd0;
    for (int cyc = 1; cyc <= LAT + 15; cyc++) begin
      @(negedge i_clk);
      if (cyc == 1) begin r_busy1 = o_busy; r_dly1 = o_dly_sel; end
      if (o_done) begin
        r_ndone++;
        if (r_lat < 0) r_lat = cyc;
      end
      if (abort_at > 0 && cyc == abort_at) i_abort = 1'b1;
      if (abort_at > 0 && cyc == abort_at + 1) begin
        r_busy_ab = o_busy; r_dly_ab = o_dly_sel; i_abort = 1'b0;
      end
      if (start_at > 0) i_start = (cyc == start_at);
    end
    i_start = 1'b0;
    r_busy_end = o_busy; r_dly_end = o_dly_sel; r_sat_end = o_sat;
  endtask

  task automatic test_reset;
    #12;
    tests_run++; if (o_dly_sel !== 9'd0) begin tests_failed++; $display("FAIL reset_dly: got %0d expected 0", o_dly_sel); end
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", o_done); end
    tests_run++; if (o_sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %b expected 0", o_sat); end
  endtask

  task automatic test_basic_300;
    @(negedge i_clk);
    pd_mode = 0; pd_par = 300;
    i_rstn = 1'b1;
    do_cal(0, 0);
    tests_run++; if (r_lat != LAT) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", r_lat, LAT); end
    tests_run++; if (r_busy1 !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_first: got %b expected 1", r_busy1); end
    tests_run++; if (r_dly1 !== 9'd256) begin tests_failed++; $display("FAIL basic_first_trial: got %0d expected 256", r_dly1); end
    tests_run++; if (r_dly_end !== 9'd299) begin tests_failed++; $display("FAIL basic_result: got %0d expected 299", r_dly_end); end
    tests_run++; if (r_sat_end !== 1'b0) begin tests_failed++; $display("FAIL basic_sat: got %b expected 0", r_sat_end); end
    tests_run++; if (r_busy_end !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after: got %b expected 0", r_busy_end); end
    tests_run++; if (r_ndone != 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d expected 1", r_ndone); end
  endtask

  task automatic test_random_thr;
    logic [8:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      pd_mode = 0; pd_par = int'($urandom_range(1, 511));
      exp_v = model_cal(0, pd_par);
      do_cal(0, 0);
      tests_run++; if (r_dly_end !== exp_v) begin tests_failed++; $display("FAIL thr_result T=%0d: got %0d expected %0d", pd_par, r_dly_end, exp_v); end
      tests_run++; if (r_sat_end !== sat_of(exp_v)) begin tests_failed++; $display("FAIL thr_sat T=%0d: got %b expected %b", pd_par, r_sat_end, sat_of(exp_v)); end
      tests_run++; if (r_lat != LAT) begin tests_failed++; $display("FAIL thr_latency: got %0d expected %0d", r_lat, LAT); end
    end
  endtask

  task automatic test_saturation;
    pd_mode = 1;
    do_cal(0, 0);
    tests_run++; if (r_dly_end !== 9'd511) begin tests_failed++; $display("FAIL sat_hi_result: got %0d expected 511", r_dly_end); end
    tests_run++; if (r_sat_end !== 1'b1) begin tests_failed++; $display("FAIL sat_hi_flag: got %b expected 1", r_sat_end); end
    pd_mode = 2;
    do_cal(0, 0);
    tests_run++; if (r_dly_end !== 9'd0) begin tests_failed++; $display("FAIL sat_lo_result: got %0d expected 0", r_dly_end); end
    tests_run++; if (r_sat_end !== 1'b1) begin tests_failed++; $display("FAIL sat_lo_flag: got %b expected 1", r_sat_end); end
  endtask

  task automatic test_vote_boundary;
    int m;
    logic [8:0] exp_v;
    pd_mode = 3; pd_par = 4;
    do_cal(0, 0);
    tests_run++; if (r_dly_end !== 9'd511) begin tests_failed++; $display("FAIL vote_4of8: got %0d expected 511", r_dly_end); end
    pd_par = 5;
    do_cal(0, 0);
    tests_run++; if (r_dly_end !== 9'd0) begin tests_failed++; $display("FAIL vote_5of8: got %0d expected 0", r_dly_end); end
    for (int i = 0; i < 2; i++) begin
      m = int'($urandom_range(0, 8));
      pd_par = m;
      exp_v = model_cal(3, m);
      do_cal(0, 0);
      tests_run++; if (r_dly_end !== exp_v) begin tests_failed++; $display("FAIL vote_rand m=%0d: got %0d expected %0d", m, r_dly_end, exp_v); end
    end
  endtask

  task automatic test_abort;
    pd_mode = 0; pd_par = 300;
    do_cal(0, 0);
    tests_run++; if (r_dly_end !== 9'd299) begin tests_failed++; $display("FAIL abort_precal: got %0d expected 299", r_dly_end); end
    pd_par = int'($urandom_range(0, 511));
    do_cal(100, 0);
    tests_run++; if (r_busy_ab !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", r_busy_ab); end
    tests_run++; if (r_dly_ab !== 9'd299) begin tests_failed++; $display("FAIL abort_dly: got %0d expected 299", r_dly_ab); end
    tests_run++; if (r_ndone != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d expected 0", r_ndone); end
    tests_run++; if (r_sat_end !== 1'b0) begin tests_failed++; $display("FAIL abort_sat: got %b expected 0", r_sat_end); end
  endtask

  task automatic test_manual;
    i_man_en = 1'b1; i_man_sel = 9'd77;
    @(negedge i_clk); @(negedge i_clk);
    tests_run++; if (o_dly_sel !== 9'd77) begin tests_failed++; $display("FAIL man_sel: got %0d expected 77", o_dly_sel); end
    i_man_en = 1'b0;
    @(negedge i_clk); @(negedge i_clk);
    tests_run++; if (o_dly_sel !== 9'd299) begin tests_failed++; $display("FAIL man_release: got %0d expected 299", o_dly_sel); end
    pd_mode = 0; pd_par = 300;
    do_cal(0, 50);
    tests_run++; if (r_lat != LAT) begin tests_failed++; $display("FAIL busy_start_latency: got %0d expected %0d", r_lat, LAT); end
    tests_run++; if (r_ndone != 1) begin tests_failed++; $display("FAIL busy_start_done_count: got %0d expected 1", r_ndone); end
  endtask

  task automatic test_async_reset;
    logic [8:0] exp_v;
    pd_mode = 1;
    do_cal(0, 0);
    pd_mode = 0; pd_par = 300;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (19) @(negedge i_clk);
    #2 i_rstn = 1'b0;
    #1;
    tests_run++; if (o_dly_sel !== 9'd0) begin tests_failed++; $display("FAIL arst_dly: got %0d expected 0", o_dly_sel); end
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL arst_busy: got %b expected 0", o_busy); end
    tests_run++; if (o_sat !== 1'b0) begin tests_failed++; $display("FAIL arst_sat: got %b expected 0", o_sat); end
    tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL arst_done: got %b expected 0", o_done); end
    @(negedge i_clk);
    pd_par = int'($urandom_range(1, 511));
    exp_v = model_cal(0, pd_par);
    i_rstn = 1'b1;
    do_cal(0, 0);
    tests_run++; if (r_dly_end !== exp_v) begin tests_failed++; $display("FAIL arst_rerun: got %0d expected %0d", r_dly_end, exp_v); end
    tests_run++; if (r_lat != LAT) begin tests_failed++; $display("FAIL arst_rerun_latency: got %0d expected %0d", r_lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_basic_300();
    test_random_thr();
    test_saturation();
    test_vote_boundary();
    test_abort();
    test_manual();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1);
  end

endmodule
